mode_sequencer: RTL and testbench
=================================

MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive identical raw samples needed to accept a new button level.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles in setup before automatic abort.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; port names are clock and reset.
REQ-004 clock  in  1  sole clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 button  in  [0:3]  raw asynchronous buttons: [0] mode/abort, [1] increment, [2] advance field, [3] enter setup.
REQ-007 time_now  in  24  live time: [23:16] hours, [15:8] minutes, [7:0] seconds, binary.
REQ-008 rezhim  out  2  display mode: 0 clock, 1 alarm, 2 stopwatch, 3 setup.
REQ-009 field_sel  out  2  0 none, 1 seconds, 2 minutes, 3 hours.
REQ-010 inc_pulse  out  1  one-cycle pulse per accepted increment.
REQ-011 load_time  out  24  shadow time being edited, same field layout as time_now.
REQ-012 load_strobe  out  1  one-cycle commit pulse; load_time valid that cycle.

Function
REQ-013 Each button SHALL pass a 2-flop synchronizer, then a debouncer that changes stable level only after DEBOUNCE_CYCLES equal samples.
REQ-014 A press SHALL be a one-cycle pulse on the stable level's 0->1 edge; holding produces no repeats.
REQ-015 FSM states SHALL be: IDLE, SNAP, SEC, MIN, HOUR, COMMIT.
REQ-016 In IDLE, press[0] SHALL cycle rezhim 0->1->2->0; press[1], press[2] ignored.
REQ-017 In IDLE with rezhim==0, press[3] SHALL go to SNAP; press[3] in rezhim 1 or 2 ignored.
REQ-018 SNAP SHALL last one cycle: copy time_now to load_time, set rezhim=3, go to SEC.
REQ-019 SEC/MIN/HOUR SHALL drive field_sel 1/2/3; field_sel=0 in all other states.
REQ-020 press[1] in SEC/MIN/HOUR SHALL increment the selected field and assert inc_pulse next cycle; 59->0 (sec, min), 23->0 (hours); other fields unchanged.
REQ-021 press[2] SHALL advance SEC->MIN->HOUR->COMMIT.
REQ-022 COMMIT SHALL last one cycle with load_strobe=1, then go to IDLE with rezhim=0.
REQ-023 press[0] in SNAP..HOUR SHALL abort to IDLE, rezhim=0, no load_strobe.
REQ-024 Same-cycle presses in setup SHALL take priority abort > advance > increment; only one acts; press[3] ignored in setup.
REQ-025 An idle counter SHALL clear on any press and abort when it reaches TIMEOUT_CYCLES in SEC/MIN/HOUR.
REQ-026 Out-of-range snapped values (e.g. seconds 60+) SHALL wrap to 0 on the next increment.
REQ-027 load_time SHALL hold its value outside setup until the next SNAP.

Reset
REQ-028 Reset SHALL force IDLE, rezhim=0, field_sel=0, inc_pulse=0, load_strobe=0, load_time=0, debouncer levels=0, counters=0.
REQ-029 Reset mid-setup SHALL discard edits with no load_strobe; reset beats all same-cycle presses.
REQ-030 A button held through reset release SHALL produce no press until released and re-pressed.

Structure
REQ-031 A shared package SHALL hold the state enum, field_sel encoding, rezhim encoding, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, field width 8.
REQ-032 Debounce SHALL be sub-module button_debounce (sync + counter + edge pulse), instantiated four times.

Verification
REQ-033 Bench SHALL cover: raw button[0] bounce 5 cycles, then stable 16 -> exactly one press, rezhim 0->1.
REQ-034 Bench SHALL cover: rezhim 0, time_now=0x17_3B_3B, press[3], press[1] -> load_time=0x17_3B_00, field_sel=1, one inc_pulse.
REQ-035 Bench SHALL cover: snap 0x05_10_20, press[2], press[1] x3, press[2] x2 -> load_strobe one cycle, load_time=0x05_13_20, rezhim 0.
REQ-036 Bench SHALL cover: in MIN, press[0] and press[2] same cycle -> abort, rezhim 0, no strobe.
REQ-037 Bench SHALL cover: in HOUR, no presses for 1000 cycles -> IDLE, rezhim 0, no strobe.
REQ-038 Bench SHALL cover: reset in MIN with button[1] held -> all outputs 0, no press until release and re-press.

Source files
------------

// File: rtl/mode_sequencer_pkg.sv
// Shared types and constants for the clock-setting mode sequencer.
// States, display mode and field encodings plus the field wrap helper.
package mode_sequencer_pkg;

    localparam int FIELD_W     = 8;
    localparam int NUM_BUTTONS = 4;

    localparam logic [FIELD_W-1:0] SEC_MAX  = 8'd59;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 8'd59;
    localparam logic [FIELD_W-1:0] HOUR_MAX = 8'd23;

    localparam int BTN_MODE  = 0;
    localparam int BTN_INC   = 1;
    localparam int BTN_ADV   = 2;
    localparam int BTN_SETUP = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNAP,
        ST_SEC,
        ST_MIN,
        ST_HOUR,
        ST_COMMIT
    } seq_state_t;

    typedef enum logic [1:0] {
        FLD_NONE,
        FLD_SEC,
        FLD_MIN,
        FLD_HOUR
    } field_sel_t;

    typedef enum logic [1:0] {
        RZ_CLOCK,
        RZ_ALARM,
        RZ_STOPWATCH,
        RZ_SETUP
    } rezhim_t;

    // Anything at or above the field maximum wraps, so bad snapped values recover.
    function automatic logic [FIELD_W-1:0] wrap_inc(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] max
    );
        return (v >= max) ? '0 : v + FIELD_W'(1);
    endfunction

endpackage

// File: rtl/mode_sequencer_debounce.sv
// Button conditioner: 2-flop synchronizer, run-length debouncer and
// single-cycle press pulse on the debounced rising edge.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic          cand_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          armed_q;
    logic          press_q;
    logic          samp;
    logic          settled;

    assign samp    = sync_q[1];
    assign settled = (cnt_q == CNT_MAX);
    assign press   = press_q;

    // armed_q stays low until a settled low level is seen, so a button
    // held through reset cannot fire until released and pressed again.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            cand_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            press_q <= 1'b0;
            if (samp != cand_q) begin
                cand_q <= samp;
                cnt_q  <= CW'(1);
            end else if (!settled) begin
                cnt_q <= cnt_q + CW'(1);
            end
            if (settled) begin
                level_q <= cand_q;
                press_q <= cand_q & ~level_q & armed_q;
                if (!cand_q) armed_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mode_sequencer.sv
// Display-mode selector and time-setting sequencer driven by four
// debounced buttons; edits a shadow copy of the time and commits it.
module mode_sequencer
    import mode_sequencer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [0:3]  button,
    input  logic [23:0] time_now,
    output logic [1:0]  rezhim,
    output logic [1:0]  field_sel,
    output logic        inc_pulse,
    output logic [23:0] load_time,
    output logic        load_strobe
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [NUM_BUTTONS-1:0] press;

    seq_state_t  state_q, state_d;
    rezhim_t     rez_q, rez_d;
    field_sel_t  fld;
    logic [23:0] shadow_q, shadow_d;
    logic        inc_q, inc_d;
    logic [TW-1:0] idle_q;
    logic        in_edit;
    logic        timeout;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock(clock),
            .reset(reset),
            .raw  (button[i]),
            .press(press[i])
        );
    end

    assign in_edit = (state_q == ST_SEC) || (state_q == ST_MIN) ||
                     (state_q == ST_HOUR);
    assign timeout = in_edit && (idle_q == TMO_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            rez_q    <= RZ_CLOCK;
            shadow_q <= '0;
            inc_q    <= 1'b0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            rez_q    <= rez_d;
            shadow_q <= shadow_d;
            inc_q    <= inc_d;
            if (!in_edit || (|press)) begin
                idle_q <= '0;
            end else if (!timeout) begin
                idle_q <= idle_q + TW'(1);
            end
        end
    end

    // In setup, abort beats advance beats increment; only one acts.
    always_comb begin
        state_d  = state_q;
        rez_d    = rez_q;
        shadow_d = shadow_q;
        inc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (press[BTN_MODE]) begin
                    unique case (rez_q)
                        RZ_CLOCK: rez_d = RZ_ALARM;
                        RZ_ALARM: rez_d = RZ_STOPWATCH;
                        default:  rez_d = RZ_CLOCK;
                    endcase
                end else if (press[BTN_SETUP] && rez_q == RZ_CLOCK) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SNAP: begin
                if (press[BTN_MODE]) begin
                    state_d = ST_IDLE;
                    rez_d   = RZ_CLOCK;
                end else begin
                    shadow_d = time_now;
                    rez_d    = RZ_SETUP;
                    state_d  = ST_SEC;
                end
            end
            ST_SEC, ST_MIN, ST_HOUR: begin
                if (press[BTN_MODE] || timeout) begin
                    state_d = ST_IDLE;
                    rez_d   = RZ_CLOCK;
                end else if (press[BTN_ADV]) begin
                    unique case (state_q)
                        ST_SEC:  state_d = ST_MIN;
                        ST_MIN:  state_d = ST_HOUR;
                        default: state_d = ST_COMMIT;
                    endcase
                end else if (press[BTN_INC]) begin
                    inc_d = 1'b1;
                    unique case (state_q)
                        ST_SEC:
                            shadow_d[7:0] = wrap_inc(shadow_q[7:0], SEC_MAX);
                        ST_MIN:
                            shadow_d[15:8] = wrap_inc(shadow_q[15:8], MIN_MAX);
                        default:
                            shadow_d[23:16] = wrap_inc(shadow_q[23:16], HOUR_MAX);
                    endcase
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                rez_d   = RZ_CLOCK;
            end
            default: begin
                state_d = ST_IDLE;
                rez_d   = RZ_CLOCK;
            end
        endcase
    end

    always_comb begin
        fld = FLD_NONE;
        unique case (state_q)
            ST_SEC:  fld = FLD_SEC;
            ST_MIN:  fld = FLD_MIN;
            ST_HOUR: fld = FLD_HOUR;
            default: fld = FLD_NONE;
        endcase
    end

    assign rezhim      = rez_q;
    assign field_sel   = fld;
    assign inc_pulse   = inc_q;
    assign load_time   = shadow_q;
    assign load_strobe = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer: debounce, mode cycling, setup
// editing, commit, abort priority, timeout and reset behaviour.
module tb_mode_sequencer;

    logic        clock;
    logic        reset;
    logic [0:3]  button;
    logic [23:0] time_now;
    logic [1:0]  rezhim;
    logic [1:0]  field_sel;
    logic        inc_pulse;
    logic [23:0] load_time;
    logic        load_strobe;

    int tests = 0;
    int fails = 0;
    int inc_cnt = 0;
    int strobe_cnt = 0;
    logic [23:0] strobe_time = '0;

    mode_sequencer #(
        .DEBOUNCE_CYCLES(16),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .button     (button),
        .time_now   (time_now),
        .rezhim     (rezhim),
        .field_sel  (field_sel),
        .inc_pulse  (inc_pulse),
        .load_time  (load_time),
        .load_strobe(load_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (inc_pulse) inc_cnt <= inc_cnt + 1;
        if (load_strobe) begin
            strobe_cnt  <= strobe_cnt + 1;
            strobe_time <= load_time;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input int b);
        button[b] = 1'b1;
        tick(25);
        button[b] = 1'b0;
        tick(25);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (rezhim !== 2'd0) begin
            fails++;
            $display("FAIL reset_rezhim: got %0d want 0", rezhim);
        end
        tests++;
        if (field_sel !== 2'd0) begin
            fails++;
            $display("FAIL reset_field: got %0d want 0", field_sel);
        end
        tests++;
        if ({inc_pulse, load_strobe} !== 2'b00) begin
            fails++;
            $display("FAIL reset_pulses: got %b want 00",
                     {inc_pulse, load_strobe});
        end
        tests++;
        if (load_time !== 24'h0) begin
            fails++;
            $display("FAIL reset_load: got %h want 000000", load_time);
        end
        tick(30);
    endtask

    task automatic test_bounce();
        for (int k = 0; k < 5; k++) begin
            button[0] = (k % 2 == 0);
            tick(1);
        end
        button[0] = 1'b1;
        tick(16);
        button[0] = 1'b0;
        tick(40);
        tests++;
        if (rezhim !== 2'd1) begin
            fails++;
            $display("FAIL bounce_one_press: got %0d want 1", rezhim);
        end
        push(0);
        tests++;
        if (rezhim !== 2'd2) begin
            fails++;
            $display("FAIL mode_to_2: got %0d want 2", rezhim);
        end
        push(0);
        tests++;
        if (rezhim !== 2'd0) begin
            fails++;
            $display("FAIL mode_wrap_0: got %0d want 0", rezhim);
        end
    endtask

    task automatic test_ignored();
        int i0;
        i0 = inc_cnt;
        push(1);
        push(2);
        tests++;
        if ({rezhim, field_sel} !== 4'b0000 || inc_cnt != i0) begin
            fails++;
            $display("FAIL idle_ignore: got rz=%0d fs=%0d inc=%0d want 0 0 0",
                     rezhim, field_sel, inc_cnt - i0);
        end
        push(0);
        push(3);
        tests++;
        if (rezhim !== 2'd1 || field_sel !== 2'd0) begin
            fails++;
            $display("FAIL setup_in_alarm: got rz=%0d fs=%0d want 1 0",
                     rezhim, field_sel);
        end
        push(0);
        push(0);
    endtask

    task automatic test_snap_inc();
        int i0, s0;
        i0 = inc_cnt;
        s0 = strobe_cnt;
        time_now = 24'h173B3B;
        push(3);
        tests++;
        if (field_sel !== 2'd1 || rezhim !== 2'd3) begin
            fails++;
            $display("FAIL snap_state: got fs=%0d rz=%0d want 1 3",
                     field_sel, rezhim);
        end
        tests++;
        if (load_time !== 24'h173B3B) begin
            fails++;
            $display("FAIL snap_copy: got %h want 173b3b", load_time);
        end
        push(1);
        tests++;
        if (load_time !== 24'h173B00) begin
            fails++;
            $display("FAIL sec_wrap: got %h want 173b00", load_time);
        end
        tests++;
        if (inc_cnt - i0 != 1) begin
            fails++;
            $display("FAIL inc_once: got %0d want 1", inc_cnt - i0);
        end
        push(0);
        tests++;
        if (rezhim !== 2'd0 || strobe_cnt != s0) begin
            fails++;
            $display("FAIL abort_sec: got rz=%0d strobes=%0d want 0 0",
                     rezhim, strobe_cnt - s0);
        end
        tests++;
        if (load_time !== 24'h173B00) begin
            fails++;
            $display("FAIL load_hold: got %h want 173b00", load_time);
        end
    endtask

    task automatic test_commit();
        int s0;
        s0 = strobe_cnt;
        time_now = 24'h051020;
        push(3);
        time_now = 24'h0A0A0A;
        push(2);
        tests++;
        if (field_sel !== 2'd2) begin
            fails++;
            $display("FAIL adv_min: got %0d want 2", field_sel);
        end
        push(1);
        push(1);
        push(1);
        push(2);
        tests++;
        if (field_sel !== 2'd3) begin
            fails++;
            $display("FAIL adv_hour: got %0d want 3", field_sel);
        end
        push(2);
        tests++;
        if (strobe_cnt - s0 != 1) begin
            fails++;
            $display("FAIL strobe_once: got %0d want 1", strobe_cnt - s0);
        end
        tests++;
        if (strobe_time !== 24'h051320) begin
            fails++;
            $display("FAIL commit_value: got %h want 051320", strobe_time);
        end
        tests++;
        if (rezhim !== 2'd0 || field_sel !== 2'd0) begin
            fails++;
            $display("FAIL commit_idle: got rz=%0d fs=%0d want 0 0",
                     rezhim, field_sel);
        end
    endtask

    task automatic test_abort_priority();
        int s0;
        s0 = strobe_cnt;
        time_now = 24'h020304;
        push(3);
        push(2);
        button[0] = 1'b1;
        button[2] = 1'b1;
        tick(25);
        button[0] = 1'b0;
        button[2] = 1'b0;
        tick(25);
        tests++;
        if ({rezhim, field_sel} !== 4'b0000 || strobe_cnt != s0) begin
            fails++;
            $display("FAIL abort_prio: got rz=%0d fs=%0d strobes=%0d want 0 0 0",
                     rezhim, field_sel, strobe_cnt - s0);
        end
    endtask

    task automatic test_timeout_wrap();
        int s0;
        s0 = strobe_cnt;
        time_now = 24'h17003C;
        push(3);
        push(1);
        tests++;
        if (load_time !== 24'h170000) begin
            fails++;
            $display("FAIL out_of_range: got %h want 170000", load_time);
        end
        push(2);
        push(2);
        push(1);
        tests++;
        if (load_time !== 24'h000000) begin
            fails++;
            $display("FAIL hour_wrap: got %h want 000000", load_time);
        end
        tick(930);
        tests++;
        if (field_sel !== 2'd3) begin
            fails++;
            $display("FAIL early_timeout: got fs=%0d want 3", field_sel);
        end
        tick(60);
        tests++;
        if ({rezhim, field_sel} !== 4'b0000 || strobe_cnt != s0) begin
            fails++;
            $display("FAIL timeout: got rz=%0d fs=%0d strobes=%0d want 0 0 0",
                     rezhim, field_sel, strobe_cnt - s0);
        end
    endtask

    task automatic test_reset_mid();
        int i0, s0;
        s0 = strobe_cnt;
        time_now = 24'h112233;
        push(3);
        push(2);
        button[0] = 1'b1;
        button[1] = 1'b1;
        tick(5);
        do_reset();
        tests++;
        if ({rezhim, field_sel, inc_pulse, load_strobe} !== 6'b0 ||
            load_time !== 24'h0) begin
            fails++;
            $display("FAIL reset_mid: got rz=%0d fs=%0d inc=%b ls=%b lt=%h want 0",
                     rezhim, field_sel, inc_pulse, load_strobe, load_time);
        end
        tick(60);
        tests++;
        if (rezhim !== 2'd0 || strobe_cnt != s0) begin
            fails++;
            $display("FAIL held_mode: got rz=%0d strobes=%0d want 0 0",
                     rezhim, strobe_cnt - s0);
        end
        button[0] = 1'b0;
        tick(30);
        i0 = inc_cnt;
        time_now = 24'h010203;
        push(3);
        tick(20);
        tests++;
        if (load_time !== 24'h010203 || inc_cnt != i0) begin
            fails++;
            $display("FAIL held_inc: got %h inc=%0d want 010203 0",
                     load_time, inc_cnt - i0);
        end
        button[1] = 1'b0;
        tick(30);
        push(1);
        tests++;
        if (load_time !== 24'h010204 || inc_cnt - i0 != 1) begin
            fails++;
            $display("FAIL repress_inc: got %h inc=%0d want 010204 1",
                     load_time, inc_cnt - i0);
        end
        push(0);
        tests++;
        if (rezhim !== 2'd0 || strobe_cnt != s0) begin
            fails++;
            $display("FAIL final_abort: got rz=%0d strobes=%0d want 0 0",
                     rezhim, strobe_cnt - s0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        button   = 4'b0000;
        time_now = 24'h0;
        test_reset();
        test_bounce();
        test_ignored();
        test_snap_inc();
        test_commit();
        test_abort_priority();
        test_timeout_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
